// File: rtl/cpu_defs.sv
// Definitions shared by the phase sequencer and the combinational control decoder:
// sequencer state encoding, the idle phase value and the HLT opcode fields.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  localparam logic [2:0] PHASE_IDLE = 3'd0;
  localparam logic [1:0] OP_ALU     = 2'b11;
  localparam logic [3:0] ALU_HLT    = 4'b1111;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[15:14] == OP_ALU) && (instr[7:4] == ALU_HLT);
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Board-side bundle of the phase sequencer: front-panel controls and IR in,
// phase and status out.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec_btn;
  logic             step_btn;
  logic             step_mode;
  logic [15:0]      instruction;
  logic [2:0]       phase;
  logic             running;
  logic             halted;
  logic             fetch_start;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output exec_btn, step_btn, step_mode, instruction,
    input  phase, running, halted, fetch_start, instr_done, instr_count
  );

  modport slave (
    input  exec_btn, step_btn, step_mode, instruction,
    output phase, running, halted, fetch_start, instr_done, instr_count
  );
endinterface

// File: rtl/phase_sequencer_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector: a held button yields a
// single one-cycle pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchronizer chain and edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign pulse = sync_r & ~prev_r;
endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: run/stop, single-step and HLT-halt control
// from two front-panel buttons, plus a retired-instruction counter.
module phase_sequencer
  import cpu_defs::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  phase_sequencer_if.slave bus
);
  localparam logic [2:0]       LAST_PHASE = 3'(NUM_PHASES);
  localparam logic [2:0]       FIRST_PHASE = 3'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t       state_r, state_nxt;
  logic [2:0]       phase_r, phase_nxt;
  logic             stop_req_r, stop_req_nxt;
  logic             halted_r, halted_nxt;
  logic [CNT_W-1:0] count_r, count_nxt;
  logic             running_r, fetch_start_r, instr_done_r;

  logic exec_p_s;
  logic step_p_s;
  logic exec_go_s;
  logic at_end_s;
  logic hlt_s;

  btn_sync u_exec_sync (.clk(clk), .rst_n(rst_n), .btn(bus.exec_btn), .pulse(exec_p_s));
  btn_sync u_step_sync (.clk(clk), .rst_n(rst_n), .btn(bus.step_btn), .pulse(step_p_s));

  assign exec_go_s = exec_p_s & ~bus.step_mode;
  assign at_end_s  = (phase_r == LAST_PHASE);
  assign hlt_s     = at_end_s & is_hlt(bus.instruction);

  // next-state, next-phase, stop request, halt flag and retire counter
  always_comb begin
    state_nxt    = state_r;
    phase_nxt    = phase_r;
    stop_req_nxt = stop_req_r;
    halted_nxt   = halted_r;
    count_nxt    = count_r;
    case (state_r)
      ST_STOP, ST_HALTED: begin
        if (exec_go_s) begin
          state_nxt  = ST_RUN;
          phase_nxt  = FIRST_PHASE;
          halted_nxt = 1'b0;
        end else if (step_p_s) begin
          state_nxt  = ST_STEP;
          phase_nxt  = FIRST_PHASE;
          halted_nxt = 1'b0;
        end else begin
          phase_nxt = PHASE_IDLE;
        end
      end
      ST_RUN: begin
        if (at_end_s) begin
          count_nxt = count_r + CNT_ONE;
          // HLT outranks a pending stop; both retire the current instruction
          if (hlt_s) begin
            state_nxt    = ST_HALTED;
            phase_nxt    = PHASE_IDLE;
            halted_nxt   = 1'b1;
            stop_req_nxt = 1'b0;
          end else if (stop_req_r) begin
            state_nxt    = ST_STOP;
            phase_nxt    = PHASE_IDLE;
            stop_req_nxt = 1'b0;
          end else begin
            phase_nxt    = FIRST_PHASE;
            stop_req_nxt = exec_go_s;
          end
        end else begin
          phase_nxt    = phase_r + 3'd1;
          stop_req_nxt = stop_req_r | exec_go_s;
        end
      end
      ST_STEP: begin
        if (at_end_s) begin
          count_nxt = count_r + CNT_ONE;
          phase_nxt = PHASE_IDLE;
          if (hlt_s) begin
            state_nxt  = ST_HALTED;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = ST_STOP;
          end
        end else begin
          phase_nxt = phase_r + 3'd1;
        end
      end
      default: begin
        state_nxt    = ST_STOP;
        phase_nxt    = PHASE_IDLE;
        stop_req_nxt = 1'b0;
      end
    endcase
  end

  // state and registered outputs, decoded from the next values so they align with phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_STOP;
      phase_r       <= PHASE_IDLE;
      stop_req_r    <= 1'b0;
      halted_r      <= 1'b0;
      count_r       <= {CNT_W{1'b0}};
      running_r     <= 1'b0;
      fetch_start_r <= 1'b0;
      instr_done_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      phase_r       <= phase_nxt;
      stop_req_r    <= stop_req_nxt;
      halted_r      <= halted_nxt;
      count_r       <= count_nxt;
      running_r     <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      fetch_start_r <= (phase_nxt == FIRST_PHASE);
      instr_done_r  <= (phase_nxt == LAST_PHASE);
    end
  end

  assign bus.phase       = phase_r;
  assign bus.running     = running_r;
  assign bus.halted      = halted_r;
  assign bus.fetch_start = fetch_start_r;
  assign bus.instr_done  = instr_done_r;
  assign bus.instr_count = count_r;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with a 4-bit counter so wrap is reachable.
module tb_phase_sequencer;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  phase_sequencer_if #(.CNT_W(4)) bus ();

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.exec_btn = 1'b0; bus.step_btn = 1'b0; bus.step_mode = 1'b0;
    bus.instruction = 16'hC000;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
    checks++; if (bus.running !== 1'b0 || bus.halted !== 1'b0) begin failures++; $display("FAIL reset_status got run=%b halt=%b exp=0,0", bus.running, bus.halted); end
    checks++; if (bus.fetch_start !== 1'b0 || bus.instr_done !== 1'b0) begin failures++; $display("FAIL reset_strobes got fs=%b id=%b exp=0,0", bus.fetch_start, bus.instr_done); end
    checks++; if (bus.instr_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count); end
    @(negedge clk); rst_n = 1'b1;
    tick(4);
    checks++; if (bus.phase !== 3'd0 || bus.running !== 1'b0) begin failures++; $display("FAIL reset_idle got ph=%0d run=%b exp=0,0", bus.phase, bus.running); end
  endtask

  // exec held: start on 3rd edge, back-to-back 1..5, one start only
  task automatic test_run_start();
    logic [2:0] exp;
    bus.exec_btn = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick(1);
      exp = (e < 3) ? 3'd0 : 3'(((e - 3) % 5) + 1);
      checks++; if (bus.phase !== exp) begin failures++; $display("FAIL run_phase edge=%0d got=%0d exp=%0d", e, bus.phase, exp); end
      checks++; if (bus.fetch_start !== (exp == 3'd1) || bus.instr_done !== (exp == 3'd5)) begin failures++; $display("FAIL run_strobes edge=%0d got fs=%b id=%b", e, bus.fetch_start, bus.instr_done); end
      checks++; if (bus.running !== (e >= 3)) begin failures++; $display("FAIL run_running edge=%0d got=%b", e, bus.running); end
      if (e == 8) begin
        checks++; if (bus.instr_count !== 4'd1) begin failures++; $display("FAIL run_count1 got=%0d exp=1", bus.instr_count); end
      end
    end
    checks++; if (bus.instr_count !== 4'd2) begin failures++; $display("FAIL run_count2 got=%0d exp=2", bus.instr_count); end
  endtask

  // new exec edge early in an instruction: it completes, then STOP
  task automatic test_stop();
    logic [2:0] exp_seq [4];
    exp_seq = '{3'd3, 3'd4, 3'd5, 3'd0};
    bus.exec_btn = 1'b0;
    tick(1);
    checks++; if (bus.phase !== 3'd2) begin failures++; $display("FAIL stop_pre got=%0d exp=2", bus.phase); end
    bus.exec_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (bus.phase !== exp_seq[i]) begin failures++; $display("FAIL stop_phase step=%0d got=%0d exp=%0d", i, bus.phase, exp_seq[i]); end
    end
    checks++; if (bus.running !== 1'b0 || bus.instr_count !== 4'd3) begin failures++; $display("FAIL stop_state got run=%b cnt=%0d exp=0,3", bus.running, bus.instr_count); end
    bus.exec_btn = 1'b0;
    tick(6);
    checks++; if (bus.phase !== 3'd0 || bus.instr_count !== 4'd3) begin failures++; $display("FAIL stop_hold got ph=%0d cnt=%0d exp=0,3", bus.phase, bus.instr_count); end
  endtask

  // step_mode: exec ignored, each step edge gives one 5-phase burst
  task automatic test_step();
    logic [2:0] exp;
    bus.step_mode = 1'b1;
    bus.exec_btn = 1'b1;
    tick(3);
    bus.exec_btn = 1'b0;
    tick(3);
    checks++; if (bus.phase !== 3'd0 || bus.running !== 1'b0) begin failures++; $display("FAIL step_exec_ignored got ph=%0d run=%b", bus.phase, bus.running); end
    for (int b = 0; b < 2; b++) begin
      bus.instruction = (b == 0) ? 16'hC000 : 16'h00F0;
      bus.step_btn = 1'b1;
      for (int e = 1; e <= 8; e++) begin
        tick(1);
        exp = (e < 3 || e > 7) ? 3'd0 : 3'(e - 2);
        checks++; if (bus.phase !== exp) begin failures++; $display("FAIL step_phase burst=%0d edge=%0d got=%0d exp=%0d", b, e, bus.phase, exp); end
        if (e == 4) bus.exec_btn = 1'b1;
      end
      checks++; if (bus.instr_count !== 4'(4 + b) || bus.halted !== 1'b0) begin failures++; $display("FAIL step_count burst=%0d got cnt=%0d halt=%b exp=%0d,0", b, bus.instr_count, bus.halted, 4 + b); end
      bus.step_btn = 1'b0;
      bus.exec_btn = 1'b0;
      tick(3);
      checks++; if (bus.phase !== 3'd0) begin failures++; $display("FAIL step_gap burst=%0d got=%0d exp=0", b, bus.phase); end
    end
    bus.step_mode = 1'b0;
  endtask

  // HLT halts after P5, exec resumes; HLT beats a coincident stop request
  task automatic test_halt();
    logic [2:0] exp;
    bus.instruction = 16'hC0F0;
    bus.exec_btn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      exp = (e < 3 || e > 7) ? 3'd0 : 3'(e - 2);
      checks++; if (bus.phase !== exp) begin failures++; $display("FAIL halt_phase edge=%0d got=%0d exp=%0d", e, bus.phase, exp); end
    end
    checks++; if (bus.halted !== 1'b1 || bus.running !== 1'b0 || bus.instr_count !== 4'd6) begin failures++; $display("FAIL halt_state got halt=%b run=%b cnt=%0d exp=1,0,6", bus.halted, bus.running, bus.instr_count); end
    bus.exec_btn = 1'b0;
    tick(4);
    checks++; if (bus.phase !== 3'd0 || bus.halted !== 1'b1) begin failures++; $display("FAIL halt_hold got ph=%0d halt=%b exp=0,1", bus.phase, bus.halted); end
    bus.instruction = 16'hC000;
    bus.exec_btn = 1'b1;
    tick(2);
    checks++; if (bus.phase !== 3'd0 || bus.halted !== 1'b1) begin failures++; $display("FAIL resume_latency got ph=%0d halt=%b exp=0,1", bus.phase, bus.halted); end
    tick(1);
    checks++; if (bus.phase !== 3'd1 || bus.halted !== 1'b0 || bus.running !== 1'b1) begin failures++; $display("FAIL resume got ph=%0d halt=%b run=%b exp=1,0,1", bus.phase, bus.halted, bus.running); end
    bus.exec_btn = 1'b0;
    tick(1);
    bus.exec_btn = 1'b1;
    bus.instruction = 16'hC0F0;
    tick(3);
    checks++; if (bus.phase !== 3'd5) begin failures++; $display("FAIL coincide_p5 got=%0d exp=5", bus.phase); end
    tick(1);
    checks++; if (bus.phase !== 3'd0 || bus.halted !== 1'b1 || bus.instr_count !== 4'd7) begin failures++; $display("FAIL coincide_halt got ph=%0d halt=%b cnt=%0d exp=0,1,7", bus.phase, bus.halted, bus.instr_count); end
    bus.exec_btn = 1'b0;
  endtask

  // 4-bit counter: retire at 15 wraps to 0 with no idle cycle
  task automatic test_wrap();
    bit found = 1'b0;
    bus.instruction = 16'hC000;
    tick(3);
    bus.exec_btn = 1'b1;
    tick(3);
    bus.exec_btn = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      if (bus.instr_count == 4'd15 && bus.instr_done == 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL wrap_reach got cnt=%0d exp=15 at P5", bus.instr_count); end
    tick(1);
    checks++; if (bus.instr_count !== 4'd0 || bus.phase !== 3'd1) begin failures++; $display("FAIL wrap got cnt=%0d ph=%0d exp=0,1", bus.instr_count, bus.phase); end
  endtask

  // async reset mid-instruction, idle after release, sync flops cleared
  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (bus.phase == 3'd4) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_reach got ph=%0d exp=4", bus.phase); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.phase !== 3'd0 || bus.running !== 1'b0 || bus.halted !== 1'b0) begin failures++; $display("FAIL rmid_async got ph=%0d run=%b halt=%b", bus.phase, bus.running, bus.halted); end
    checks++; if (bus.fetch_start !== 1'b0 || bus.instr_done !== 1'b0 || bus.instr_count !== 4'd0) begin failures++; $display("FAIL rmid_outs got fs=%b id=%b cnt=%0d", bus.fetch_start, bus.instr_done, bus.instr_count); end
    @(negedge clk); rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      checks++; if (bus.phase !== 3'd0 || bus.running !== 1'b0) begin failures++; $display("FAIL rmid_idle edge=%0d got ph=%0d run=%b", e, bus.phase, bus.running); end
    end
    rst_n = 1'b0;
    bus.exec_btn = 1'b1;
    #10;
    @(negedge clk); rst_n = 1'b1;
    tick(2);
    checks++; if (bus.phase !== 3'd0) begin failures++; $display("FAIL rel_latency got=%0d exp=0", bus.phase); end
    tick(1);
    checks++; if (bus.phase !== 3'd1 || bus.running !== 1'b1) begin failures++; $display("FAIL rel_start got ph=%0d run=%b exp=1,1", bus.phase, bus.running); end
    bus.exec_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_stop();
    test_step();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Generates the 3-bit `phase` that the combinational control decoder consumes.
- Phase 0 means idle with all strobes off; phases 1–5 are P1–P5 of one instruction.
- Provides run/stop, single-step and HLT-halt control from two front-panel buttons, and counts retired instructions.
- Sits between the board I/O and the control decoder, in the clk domain of the datapath.

## Interface
- `NUM_PHASES`, default 5: number of active phases per instruction. Legal range is 2–7.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk` in 1: system clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `exec_btn` in 1: run/stop button, asynchronous level.
- `step_btn` in 1: single-step button, asynchronous level.
- `step_mode` in 1: when 1, the exec button is ignored and only step_btn starts instructions. Static, synchronous.
- `instruction` in 16: current IR contents. Valid from P2 onward.
- `phase` out 3: 0 means idle; 1..NUM_PHASES means the active phase.
- `running` out 1: 1 while an instruction is in flight or free-run is armed.
- `halted` out 1: 1 after an HLT instruction has retired.
- `fetch_start` out 1: high exactly when phase==1.
- `instr_done` out 1: high exactly when phase==NUM_PHASES.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
Reset values: phase=0, running=0, halted=0, fetch_start=0, instr_done=0, instr_count=0, state=STOP, stop_req=0.

Button handling:
- Each button passes through a 2-flop synchronizer followed by a rising-edge detector.
- The result is a 1-cycle pulse: `exec_p` or `step_p`.
- Holding a button produces exactly one pulse.

States:
- **STOP**: phase=0.
  - exec_p with step_mode=0: go to RUN.
  - step_p: go to STEP.
  - exec_p and step_p in the same cycle: exec wins if step_mode=0; otherwise step.
- **RUN**: phase advances 1→2→…→NUM_PHASES→1 every cycle.
  - exec_p in RUN sets stop_req.
  - At phase==NUM_PHASES, evaluated in priority order:
    1. HLT detected: go to HALTED.
    2. stop_req: go to STOP and clear stop_req.
    3. Otherwise: phase=1.
- **STEP**: same phase advance as RUN. At phase==NUM_PHASES go to HALTED if HLT is detected, else to STOP. exec_p is ignored.
- **HALTED**: phase=0, halted=1.
  - exec_p with step_mode=0: clear halted, go to RUN.
  - step_p: clear halted, go to STEP.

HLT detection:
- Decode is `instruction[15:14]==2'b11 && instruction[7:4]==4'b1111`.
- It is sampled only while phase==NUM_PHASES.

Outputs and counter:
- `running` is 1 in RUN and STEP, 0 in STOP and HALTED.
- `instr_count` increments on the edge that leaves phase==NUM_PHASES, for every instruction including HLT.
- The counter wraps from all-ones to 0.

## Timing
- A button that first reads high at edge k produces its pulse during the cycle after edge k+1. The new state and phase=1 are visible after edge k+2. Start latency is therefore 3 edges.
- Back-to-back instructions in RUN have no idle cycle: phase goes NUM_PHASES→1 on the next edge.
- Stopping always completes the current instruction; phase never leaves a nonzero value except toward 1 or 0 at the NUM_PHASES boundary.
- If stop_req and HLT coincide, HALTED wins.
- Reset asserted mid-instruction forces phase=0 immediately and clears all state, including synchronizer flops.
- On rst_n deassertion, the first state change is no earlier than the third edge.
- `fetch_start` and `instr_done` are decoded from registered phase and are glitch-free.

## Structure
- Shared package `cpu_defs`, holding:
  - state encoding (STOP=0, RUN=1, STEP=2, HALTED=3);
  - `PHASE_IDLE=3'd0`;
  - `OP_ALU=2'b11` and `ALU_HLT=4'b1111`, which the control decoder also uses.
- Sub-module `btn_sync`: 2-flop synchronizer plus edge detector with async active-low reset. Instantiated twice.

## Test plan
- Reset, then exec_btn high for 10 cycles with an ADD instruction (`16'hC000`) → phase sequence 1,2,3,4,5,1… starting at the 3rd edge. Exactly one start; instr_count=2 after 10 cycles.
- In RUN, pulse exec_btn during P3 → current instruction finishes, phase=0 after the P5 edge, running=0, instr_count increments by one for that instruction.
- step_mode=1, pulse step_btn twice with gaps → two 5-phase bursts separated by phase=0 and instr_count=2. exec_btn pulses are ignored.
- In RUN, instruction=`16'hC0F0` (HLT) → halted=1, phase=0 after P5, instr_count includes the HLT. A subsequent exec_btn resumes RUN and clears halted.
- Preload instr_count near wrap by running 65535 instructions (or force CNT_W=4 with 15) → the next retire shows 0.
- Assert rst_n low during P4 → phase=0 and all outputs at reset values in the same cycle, asynchronously. After release, no activity until a new button edge.
